// File: rtl/fifo_arbiter_if.sv
// Bundle between the requesters, the arbiter and the downstream FIFO write port.
// Handshake: a beat moves on a rising edge where val and rdy are both high; val
// may not depend on rdy, and data/last are only meaningful while val is high.
interface fifo_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_val;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [WIDTH-1:0]         data_out;
    logic [ID_WIDTH-1:0]      data_out_id;
    logic                     data_out_last;
    logic                     data_out_val;
    logic                     data_out_rdy;

    // Arbiter side.
    modport slave (
        input  req_data, req_val, req_last, data_out_rdy,
        output req_rdy, data_out, data_out_id, data_out_last, data_out_val
    );

    // Requesters plus FIFO side.
    modport master (
        output req_data, req_val, req_last, data_out_rdy,
        input  req_rdy, data_out, data_out_id, data_out_last, data_out_val
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among NUM_REQ
// requesters; a grant is held until the owner's last beat is accepted.
module fifo_arbiter #(
    parameter int  WIDTH    = 8,
    parameter int  NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    fifo_arbiter_if.slave       bus,
    output logic                dbg_state_o,
    output logic [ID_WIDTH-1:0] dbg_grant_o,
    output logic [ID_WIDTH-1:0] dbg_ptr_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] grant_q;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_d;

    logic                busy;
    logic                beat_fire;
    logic                pkt_done;
    logic [NUM_REQ-1:0]  rearb_vec;
    logic                any_idle;
    logic                any_rearb;
    logic [ID_WIDTH-1:0] win_idle;
    logic [ID_WIDTH-1:0] win_rearb;

    // Returns {found, index}: first set bit of vec at or after start, wrapping
    // explicitly modulo NUM_REQ so non-power-of-2 counts never alias.
    function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]  vec,
                                                  input logic [ID_WIDTH-1:0] start);
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        logic [ID_WIDTH-1:0] cand;
        int                  pos;
        found = 1'b0;
        idx   = start;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos  = (int'(start) + i) % NUM_REQ;
            cand = ID_WIDTH'(pos);
            if (!found && vec[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        busy      = (state_q == BUSY);
        beat_fire = busy && bus.req_val[grant_q] && bus.data_out_rdy;
        pkt_done  = beat_fire && bus.req_last[grant_q];
        ptr_d     = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        // The finishing requester is excluded so a sole requester takes the IDLE detour.
        rearb_vec = bus.req_val & ~(NUM_REQ'(1) << grant_q);
        {any_idle, win_idle}   = rr_pick(bus.req_val, ptr_q);
        {any_rearb, win_rearb} = rr_pick(rearb_vec, ptr_d);
    end

    always_comb begin
        bus.data_out      = bus.req_data[grant_q*WIDTH +: WIDTH];
        bus.data_out_last = bus.req_last[grant_q];
        bus.data_out_val  = busy && bus.req_val[grant_q];
        bus.data_out_id   = grant_q;
        bus.req_rdy       = '0;
        if (busy) begin
            bus.req_rdy[grant_q] = bus.data_out_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_idle) begin
                        grant_q <= win_idle;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (pkt_done) begin
                        ptr_q <= ptr_d;
                        if (any_rearb) begin
                            grant_q <= win_rearb;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_grant_o = grant_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter: directed scenarios plus a random soak
// feeding a depth-10 FIFO model.
module tb_fifo_arbiter;
  localparam int W  = 8;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int EW = IW + 1 + W;

  logic clk;
  logic reset;
  logic          dbg_state;
  logic [IW-1:0] dbg_grant;
  logic [IW-1:0] dbg_ptr;

  fifo_arbiter_if #(.WIDTH(W), .NUM_REQ(NR)) bus ();

  fifo_arbiter #(.WIDTH(W), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_grant_o (dbg_grant),
    .dbg_ptr_o   (dbg_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [W:0]    src_q[NR][$];
  logic [W:0]    exp_id_q[NR][$];
  logic [EW-1:0] exp_q[$];
  logic [NR-1:0] mute;
  int n_vec;
  int n_err;

  logic          fired;
  logic [IW-1:0] obs_id;
  logic          obs_last;
  logic [W-1:0]  obs_data;
  logic [EW-1:0] obs_beat;

  // driver: one cycle of stimulus from the per-requester packet queues
  task automatic drive_cycle(input logic rdy, input logic rst);
    logic [NR*W-1:0] d;
    logic [NR-1:0]   v;
    logic [NR-1:0]   l;
    @(negedge clk);
    d = '0;
    v = '0;
    l = '0;
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0 && !mute[k]) begin
        v[k] = 1'b1;
        d[k*W +: W] = src_q[k][0][W-1:0];
        l[k] = src_q[k][0][W];
      end else begin
        d[k*W +: W] = W'($urandom_range(0, 255));
      end
    end
    bus.req_data = d;
    bus.req_val = v;
    bus.req_last = l;
    bus.data_out_rdy = rdy;
    reset = rst;
    #1;
    fired = bus.data_out_val && bus.data_out_rdy && !rst;
    obs_id = bus.data_out_id;
    obs_last = bus.data_out_last;
    obs_data = bus.data_out;
    obs_beat = {obs_id, obs_last, obs_data};
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin
        if (bus.req_rdy[k] && v[k]) void'(src_q[k].pop_front());
      end
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < NR; k++) begin
      src_q[k].delete();
      exp_id_q[k].delete();
    end
    exp_q.delete();
    mute = '0;
    drive_cycle(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    mute = '0;
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
    n_vec++;
    if ({dbg_state, dbg_grant, dbg_ptr} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_regs: got state/grant/ptr %b/%0d/%0d expected 0/0/0", dbg_state, dbg_grant, dbg_ptr);
    end
    n_vec++;
    if ({bus.data_out_val, bus.req_rdy, bus.data_out_id} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outs: got val/rdy/id %b/%b/%0d expected 0/0000/0", bus.data_out_val, bus.req_rdy, bus.data_out_id);
    end
  endtask

  task automatic test_single();
    logic [EW-1:0] exp;
    src_q[1].push_back({1'b0, 8'hA1});
    src_q[1].push_back({1'b0, 8'hA2});
    src_q[1].push_back({1'b1, 8'hA3});
    exp_q.push_back({2'd1, 1'b0, 8'hA1});
    exp_q.push_back({2'd1, 1'b0, 8'hA2});
    exp_q.push_back({2'd1, 1'b1, 8'hA3});
    drive_cycle(1'b1, 1'b0);
    n_vec++;
    if (bus.data_out_val !== 1'b0) begin
      n_err++;
      $display("FAIL single_req_cycle: got val %b expected 0", bus.data_out_val);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0);
      n_vec++;
      if (!fired || bus.req_rdy !== 4'b0010) begin
        n_err++;
        $display("FAIL single_handshake: got fired %b rdy %b expected 1 0010", fired, bus.req_rdy);
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (obs_beat !== exp) begin
        n_err++;
        $display("FAIL single_beat: got %h expected %h", obs_beat, exp);
      end
    end
    drive_cycle(1'b1, 1'b0);
    n_vec++;
    if ({dbg_state, dbg_ptr, bus.data_out_val} !== {1'b0, 2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL single_idle: got state/ptr/val %b/%0d/%b expected 0/2/0", dbg_state, dbg_ptr, bus.data_out_val);
    end
  endtask

  task automatic test_round_robin();
    logic [EW-1:0] exp;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < NR; k++) begin
        src_q[k].push_back({1'b1, 8'(k*16 + n)});
        exp_q.push_back({2'(k), 1'b1, 8'(k*16 + n)});
      end
    end
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (!fired || obs_beat !== exp) begin
        n_err++;
        $display("FAIL rr_order: beat %0d got fired %b %h expected %h", i, fired, obs_beat, exp);
      end
    end
    drive_cycle(1'b1, 1'b0);
    n_vec++;
    if ({dbg_state, dbg_ptr} !== 3'b000) begin
      n_err++;
      $display("FAIL rr_end: got state/ptr %b/%0d expected 0/0", dbg_state, dbg_ptr);
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] exp;
    do_reset();
    src_q[3].push_back({1'b0, 8'h31});
    src_q[3].push_back({1'b1, 8'h32});
    exp_q.push_back({2'd3, 1'b0, 8'h31});
    exp_q.push_back({2'd3, 1'b1, 8'h32});
    exp_q.push_back({2'd0, 1'b1, 8'h55});
    drive_cycle(1'b1, 1'b0);
    src_q[0].push_back({1'b1, 8'h55});
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0);
      n_vec++;
      if ({bus.data_out_val, bus.data_out_id, bus.data_out, bus.req_rdy} !== {1'b1, 2'd3, 8'h31, 4'b0000}) begin
        n_err++;
        $display("FAIL bp_hold: got val/id/data/rdy %b/%0d/%h/%b expected 1/3/31/0000",
                 bus.data_out_val, bus.data_out_id, bus.data_out, bus.req_rdy);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (!fired || obs_beat !== exp) begin
        n_err++;
        $display("FAIL bp_release: beat %0d got fired %b %h expected %h", i, fired, obs_beat, exp);
      end
    end
  endtask

  task automatic test_same_requester();
    logic [EW-1:0] exp;
    do_reset();
    src_q[2].push_back({1'b1, 8'h61});
    src_q[2].push_back({1'b1, 8'h62});
    exp_q.push_back({2'd2, 1'b1, 8'h61});
    exp_q.push_back({2'd2, 1'b1, 8'h62});
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (!fired || obs_beat !== exp) begin
      n_err++;
      $display("FAIL same_first: got fired %b %h expected %h", fired, obs_beat, exp);
    end
    drive_cycle(1'b1, 1'b0);
    n_vec++;
    if ({dbg_state, bus.data_out_val} !== 2'b00) begin
      n_err++;
      $display("FAIL same_bubble: got state/val %b/%b expected 0/0", dbg_state, bus.data_out_val);
    end
    drive_cycle(1'b1, 1'b0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (!fired || obs_beat !== exp) begin
      n_err++;
      $display("FAIL same_second: got fired %b %h expected %h", fired, obs_beat, exp);
    end
    drive_cycle(1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    logic [EW-1:0] exp;
    n_vec++;
    if ({dbg_state, dbg_ptr} !== {1'b0, 2'd3}) begin
      n_err++;
      $display("FAIL wrap_start: got state/ptr %b/%0d expected 0/3", dbg_state, dbg_ptr);
    end
    src_q[0].push_back({1'b1, 8'h70});
    src_q[2].push_back({1'b1, 8'h72});
    exp_q.push_back({2'd0, 1'b1, 8'h70});
    exp_q.push_back({2'd2, 1'b1, 8'h72});
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (!fired || obs_beat !== exp) begin
        n_err++;
        $display("FAIL wrap_order: beat %0d got fired %b %h expected %h", i, fired, obs_beat, exp);
      end
    end
  endtask

  task automatic test_drop();
    logic [EW-1:0] exp;
    do_reset();
    src_q[1].push_back({1'b0, 8'h81});
    src_q[1].push_back({1'b1, 8'h82});
    exp_q.push_back({2'd1, 1'b0, 8'h81});
    exp_q.push_back({2'd1, 1'b1, 8'h82});
    exp_q.push_back({2'd0, 1'b1, 8'h80});
    drive_cycle(1'b1, 1'b0);
    src_q[0].push_back({1'b1, 8'h80});
    drive_cycle(1'b1, 1'b0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    if (!fired || obs_beat !== exp) begin
      n_err++;
      $display("FAIL drop_first: got fired %b %h expected %h", fired, obs_beat, exp);
    end
    mute[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0);
      n_vec++;
      if ({bus.data_out_val, bus.data_out_id, dbg_state} !== {1'b0, 2'd1, 1'b1}) begin
        n_err++;
        $display("FAIL drop_hold: got val/id/state %b/%0d/%b expected 0/1/1",
                 bus.data_out_val, bus.data_out_id, dbg_state);
      end
    end
    mute[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (!fired || obs_beat !== exp) begin
        n_err++;
        $display("FAIL drop_resume: beat %0d got fired %b %h expected %h", i, fired, obs_beat, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] exp;
    do_reset();
    src_q[2].push_back({1'b1, 8'h90});
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b0);
    n_vec++;
    if (dbg_ptr !== 2'd3) begin
      n_err++;
      $display("FAIL rmid_ptr_pre: got ptr %0d expected 3", dbg_ptr);
    end
    for (int b = 0; b < 4; b++) src_q[2].push_back({b == 3, 8'(8'h91 + b)});
    exp_q.push_back({2'd2, 1'b0, 8'h91});
    exp_q.push_back({2'd2, 1'b0, 8'h92});
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (!fired || obs_beat !== exp) begin
        n_err++;
        $display("FAIL rmid_beat: beat %0d got fired %b %h expected %h", i, fired, obs_beat, exp);
      end
    end
    drive_cycle(1'b1, 1'b1);
    src_q[2].delete();
    src_q[2].push_back({1'b1, 8'hB2});
    src_q[3].push_back({1'b1, 8'hB3});
    exp_q.push_back({2'd2, 1'b1, 8'hB2});
    exp_q.push_back({2'd3, 1'b1, 8'hB3});
    drive_cycle(1'b1, 1'b0);
    n_vec++;
    if ({bus.data_out_val, bus.req_rdy, dbg_state, dbg_ptr} !== 8'b0) begin
      n_err++;
      $display("FAIL rmid_after: got val/rdy/state/ptr %b/%b/%b/%0d expected 0/0000/0/0",
               bus.data_out_val, bus.req_rdy, dbg_state, dbg_ptr);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_vec++;
      if (!fired || obs_beat !== exp) begin
        n_err++;
        $display("FAIL rmid_regrant: beat %0d got fired %b %h expected %h", i, fired, obs_beat, exp);
      end
    end
  endtask

  task automatic test_soak();
    int fcnt;
    int cin[NR];
    int cout[NR];
    logic in_pkt;
    logic [IW-1:0] cur;
    logic [W:0] exp;
    int len;
    logic [W-1:0] d;
    int cyc;
    logic pending;
    do_reset();
    fcnt = 0;
    in_pkt = 1'b0;
    cur = '0;
    for (int k = 0; k < NR; k++) begin
      cin[k] = 0;
      cout[k] = 0;
    end
    cyc = 0;
    pending = 1'b1;
    while (cyc < 1000 || (pending && cyc < 3000)) begin
      for (int k = 0; k < NR; k++) begin
        if (cyc < 1000 && src_q[k].size() == 0 && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            d = W'($urandom_range(0, 255));
            src_q[k].push_back({b == len - 1, d});
            exp_id_q[k].push_back({b == len - 1, d});
            cin[k]++;
          end
        end
        mute[k] = (cyc < 1000) && ($urandom_range(0, 7) == 0);
      end
      if (fcnt > 0 && $urandom_range(0, 1) == 1) fcnt--;
      drive_cycle(fcnt < 10, 1'b0);
      if (fired) begin
        fcnt++;
        cout[obs_id]++;
        n_vec++;
        if (in_pkt && obs_id !== cur) begin
          n_err++;
          $display("FAIL soak_interleave: got id %0d expected %0d", obs_id, cur);
        end
        cur = obs_id;
        in_pkt = !obs_last;
        exp = (exp_id_q[obs_id].size() > 0) ? exp_id_q[obs_id].pop_front() : 'x;
        n_vec++;
        if ({obs_last, obs_data} !== exp) begin
          n_err++;
          $display("FAIL soak_beat: id %0d got %h expected %h", obs_id, {obs_last, obs_data}, exp);
        end
      end
      pending = 1'b0;
      for (int k = 0; k < NR; k++) if (src_q[k].size() > 0) pending = 1'b1;
      cyc++;
    end
    n_vec++;
    if (pending) begin
      n_err++;
      $display("FAIL soak_drain: got beats pending after %0d cycles expected none", cyc);
    end
    for (int k = 0; k < NR; k++) begin
      n_vec++;
      if (cout[k] !== cin[k] || exp_id_q[k].size() != 0) begin
        n_err++;
        $display("FAIL soak_count: id %0d got %0d beats out expected %0d", k, cout[k], cin[k]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    mute = '0;
    bus.req_data = '0;
    bus.req_val = '0;
    bus.req_last = '0;
    bus.data_out_rdy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_same_requester();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Round-robin, packet-aware arbiter that shares one `fifo` write port among `NUM_REQ` requesters. Each requester presents a valid/ready stream with a `last` marker. The arbiter grants one requester at a time and holds that grant until the requester's `last` beat is accepted, so packets are never interleaved in the shared FIFO. It sits directly in front of the `fifo` instance: `data_out*` connects to the FIFO's `data_in`, `data_in_val` and `data_in_rdy`.

## Interface
- `WIDTH`, 8, data width per beat; must match the downstream FIFO's `WIDTH`.
- `NUM_REQ`, 4, number of requesters; legal range is 2 to 16.
- `ID_WIDTH`, `$clog2(NUM_REQ)`, width of the source-ID field; derived, never overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_data`  in  `NUM_REQ*WIDTH`  requester data; requester k occupies bits `[k*WIDTH +: WIDTH]`.
- `req_val`  in  `NUM_REQ`  per-requester valid.
- `req_last`  in  `NUM_REQ`  per-requester end-of-packet flag, qualified by `req_val`.
- `req_rdy`  out  `NUM_REQ`  per-requester ready; one-hot or zero.
- `data_out`  out  `WIDTH`  granted requester's data.
- `data_out_id`  out  `ID_WIDTH`  index of the granted requester.
- `data_out_last`  out  1  granted requester's `last` flag.
- `data_out_val`  out  1  beat valid toward the FIFO.
- `data_out_rdy`  in  1  FIFO ready (the FIFO's `data_in_rdy`).

## Operation
- State registers:
  - `state` ∈ {IDLE, BUSY}
  - `grant` [ID_WIDTH-1:0]
  - `ptr` [ID_WIDTH-1:0]: the highest-priority index for the next arbitration.
- Arbitration function:
  - Search `req_val` starting at `ptr`, ascending and wrapping modulo `NUM_REQ`.
  - The first asserted index wins.
  - Indices ≥ `NUM_REQ` never exist, and the wrap is explicit modulo `NUM_REQ`, not a power-of-2 truncation.
- IDLE:
  - `data_out_val`=0 and `req_rdy`=0.
  - If any `req_val` is high: `grant` ← winner, go to BUSY.
- BUSY: outputs are driven from requester `grant`:
  - `data_out_val` = `req_val[grant]`
  - `data_out`, `data_out_last` = that requester's fields
  - `data_out_id` = `grant`
  - `req_rdy[grant]` = `data_out_rdy`; all other `req_rdy` = 0.
- Transfer: a beat transfers when `data_out_val && data_out_rdy` on a rising edge.
- Transfer with `last`=0: stay in BUSY with the same grant.
- Transfer with `last`=1:
  - `ptr` ← (`grant`+1) mod `NUM_REQ`.
  - Re-arbitrate in the same edge using the new `ptr`, over the `req_val` with the finishing requester's bit masked.
    - If any remain: `grant` ← winner, stay BUSY.
    - Otherwise: go to IDLE.
  - If only the finishing requester is still requesting, it is re-granted through the IDLE cycle.
- Fairness: no requester waits more than `NUM_REQ`-1 packets once its `req_val` is high.
- Requester drops `req_val[grant]` mid-packet: the grant is held (`data_out_val`=0) until the packet's `last` beat transfers. No timeout.
- `data_out_id` is constant for every beat of a packet.

## Timing
- Reset values: `state`=IDLE, `grant`=0, `ptr`=0, `req_rdy`=0, `data_out_val`=0.
  - `data_out_id`=0.
  - `data_out`, `data_out_last` reflect requester 0's inputs but are don't-care while `data_out_val`=0.
- `reset` wins over every other event, including a mid-packet transfer. Any partial packet already in the FIFO stays there; the arbiter does not track it.
- Latency from IDLE: `req_val` sampled high at edge N gives the first beat presentable in cycle N+1.
- Back-to-back packets from different requesters: zero bubble cycles.
- Back-to-back packets from the same sole requester: one bubble cycle.
- Outputs are combinational from registered `grant`/`state` plus requester inputs. Arbitration never changes `grant` while a beat is pending and unaccepted.
- Throughput: one beat per cycle while the FIFO is not full (`data_out_rdy`=1).

## Test plan
- Reset mid-packet:
  - Grant requester 2, transfer 2 of 4 beats, assert `reset` for 1 cycle.
  - Required: the next cycle has `data_out_val`=0 and `req_rdy`=0. Requester 2 re-requesting is granted from `ptr`=0 priority.
- Single packet:
  - Requester 1 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3) with `data_out_rdy`=1.
  - Required: `data_out` shows 0xA1–0xA3 on consecutive cycles starting 1 cycle after request, `data_out_id`=1, then `ptr`=2 and the arbiter goes to IDLE.
- Round-robin:
  - All 4 requesters hold 1-beat packets continuously.
  - Required: grant order 0,1,2,3,0,… with no bubble cycles.
- Backpressure:
  - During a 2-beat packet from requester 3, hold `data_out_rdy`=0 for 5 cycles while requester 0 also requests.
  - Required: `data_out` and `data_out_id`=3 remain stable, `req_rdy`=0. Requester 0 is granted only after requester 3's last beat.
- Wrap and random soak:
  - Start with `ptr`=3 and requesters 0 and 2 active. Required: requester 0 is granted first, then 2.
  - Then run 1000 random-cycle stimulus into a depth-10 `fifo`. Required: no interleaved packets, and the per-ID beat counts out equal the counts in.
